// File: rtl/morse_round_ctrl_if.sv
// Player-facing bundle of the morse round controller: commit/phase pulses and the symbol
// travel in, and the round status travels out.
interface morse_round_ctrl_if #(
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 4
);
    logic              tick;
    logic              next_pulse;
    logic              done_pulse;
    logic [WIDTH-1:0]  symbol_in;
    logic [1:0]        state;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [WIDTH-1:0]  stored_symbol;
    logic [ADDR_W:0]   match_cnt;
    logic              overflow;
    logic              game_over;
    logic              win;

    modport master (
        output tick, next_pulse, done_pulse, symbol_in,
        input  state, wr_ptr, rd_ptr, stored_symbol, match_cnt, overflow, game_over, win
    );

    modport slave (
        input  tick, next_pulse, done_pulse, symbol_in,
        output state, wr_ptr, rd_ptr, stored_symbol, match_cnt, overflow, game_over, win
    );
endinterface

// File: rtl/morse_round_ctrl.sv
// Record/challenge controller: player 1 records symbols, player 2 replays them and is scored.
// Define MORSE_TIMEOUT_EN to end the challenge after TIMEOUT_TICKS idle tick pulses.
module morse_round_ctrl #(
    parameter int WIDTH         = 10,
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter int TIMEOUT_TICKS = 10
) (
    input logic               clock,
    input logic               resetn,
    morse_round_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        START     = 2'd0,
        RECORD    = 2'd1,
        CHALLENGE = 2'd2,
        RESULT    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    state_t           state_q;
    logic [ADDR_W:0]  wr_ptr_q;
    logic [ADDR_W:0]  rd_ptr_q;
    logic [ADDR_W:0]  match_q;
    logic [WIDTH-1:0] stored_q;
    logic             overflow_q;
    logic             game_over_q;
    logic             win_q;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data;
    logic [ADDR_W:0]  match_next;
    logic             hit;
    logic             exhausted;
    logic             timed_out;
    logic             do_write;

    assign rd_data    = mem[rd_ptr_q[ADDR_W-1:0]];
    assign hit        = bus.next_pulse && (bus.symbol_in == rd_data);
    assign match_next = match_q + (ADDR_W + 1)'(hit);
    assign exhausted  = (rd_ptr_q == wr_ptr_q);
    assign do_write   = (state_q == RECORD) && bus.next_pulse && (wr_ptr_q != FULL);

`ifdef MORSE_TIMEOUT_EN
    localparam int               CNT_W      = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] TICK_LIMIT = CNT_W'(TIMEOUT_TICKS);

    logic [CNT_W-1:0] tick_cnt;

    assign timed_out = (tick_cnt == TICK_LIMIT);

    // Idle-tick counter lives only inside CHALLENGE; any player entry or leaving the phase zeroes it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
        end else if (state_q != CHALLENGE || exhausted || timed_out ||
                     bus.done_pulse || bus.next_pulse) begin
            tick_cnt <= '0;
        end else if (bus.tick) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_TICKS;
    logic unused_tick;
    assign unused_tick = bus.tick;
    assign timed_out   = 1'b0;
`endif

    // Storage is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= bus.symbol_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= START;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            match_q     <= '0;
            stored_q    <= '0;
            overflow_q  <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            stored_q <= rd_data;
            case (state_q)
                START: begin
                    game_over_q <= 1'b0;
                    win_q       <= 1'b0;
                    if (bus.done_pulse) begin
                        state_q    <= RECORD;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        match_q    <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                RECORD: begin
                    if (bus.next_pulse) begin
                        if (wr_ptr_q == FULL) begin
                            overflow_q <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                    // A write on the same edge counts toward the non-empty requirement.
                    if (bus.done_pulse && (wr_ptr_q != '0 || bus.next_pulse)) begin
                        state_q <= CHALLENGE;
                    end
                end
                CHALLENGE: begin
                    if (exhausted || timed_out) begin
                        state_q     <= RESULT;
                        game_over_q <= 1'b1;
                        win_q       <= (match_q == wr_ptr_q);
                    end else begin
                        if (bus.next_pulse) begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                            match_q  <= match_next;
                        end
                        if (bus.done_pulse) begin
                            state_q     <= RESULT;
                            game_over_q <= 1'b1;
                            win_q       <= (match_next == wr_ptr_q);
                        end
                    end
                end
                RESULT: begin
                    if (bus.done_pulse) begin
                        state_q     <= START;
                        game_over_q <= 1'b0;
                        win_q       <= 1'b0;
                    end
                end
                default: state_q <= START;
            endcase
        end
    end

    assign bus.state         = state_q;
    assign bus.wr_ptr        = wr_ptr_q;
    assign bus.rd_ptr        = rd_ptr_q;
    assign bus.match_cnt     = match_q;
    assign bus.stored_symbol = stored_q;
    assign bus.overflow      = overflow_q;
    assign bus.game_over     = game_over_q;
    assign bus.win           = win_q;
endmodule
